fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter IW, default 16, giving the instruction word width in bits.
REQ-002 The block SHALL have parameter OPW, default 4, giving the opcode field width, taken from instr[IW-1:IW-OPW].
REQ-003 The block SHALL have parameter WAIT_OP, default 4'hE, the opcode that stalls for the external handshake.
REQ-004 The block SHALL have parameter HALT_OP, default 4'hF, the opcode that stops fetching permanently until reset.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port pc, input, 6 bits: current program counter from the PC register; also the program-memory address.
REQ-008 The block SHALL have port imem_data, input, IW bits: synchronous program-memory read data, valid 1 cycle after pc is presented.
REQ-009 The block SHALL have port ext_ready, input, 1 bit: asynchronous external handshake (push-button/switch).
REQ-010 The block SHALL have port incr, output, 1 bit: single-cycle pulse telling the PC to advance by one.
REQ-011 The block SHALL have port instr, output, IW bits: instruction register feeding the decoder.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: high for exactly one cycle per executed instruction.
REQ-013 The block SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-014 The block SHALL implement the FSM states FETCH, LATCH, EXEC, WAIT, REL and HALT.
REQ-015 In FETCH, the FSM SHALL go to LATCH unconditionally, with pc held stable (incr=0) so the memory registers address pc.
REQ-016 In LATCH, instr SHALL load imem_data at the clock edge, and the FSM SHALL go to EXEC.
REQ-017 In EXEC, instr_valid SHALL be 1 and the next state SHALL be chosen by the opcode op=instr[IW-1:IW-OPW], as given by REQ-018 to REQ-020.
REQ-018 In EXEC with op not equal to WAIT_OP or HALT_OP, incr SHALL be 1 and the next state SHALL be FETCH, giving 3 cycles per instruction.
REQ-019 In EXEC with op==WAIT_OP, incr SHALL be 0 and the next state SHALL be WAIT.
REQ-020 In EXEC with op==HALT_OP, incr SHALL be 0 and the next state SHALL be HALT.
REQ-021 In WAIT, the FSM SHALL remain until ext_sync==1, then go to REL.
REQ-022 In REL, the FSM SHALL remain until ext_sync==0; in the cycle ext_sync==0, incr SHALL be 1 and the next state SHALL be FETCH.
REQ-023 In HALT, the FSM SHALL remain there, with incr=0 and instr_valid=0, ignoring ext_ready.
REQ-024 ext_sync SHALL be ext_ready passed through a 2-flop synchronizer, giving a 2-cycle latency; the block SHALL use no raw ext_ready in any logic.
REQ-025 incr, instr_valid and halted SHALL be decoded from the state register only, so they are glitch-free and the PC samples incr on the same edge that leaves the state.
REQ-026 incr SHALL never be high for 2 consecutive cycles, and SHALL be high at most once per instruction.
REQ-027 instr SHALL change only on the LATCH edge and SHALL hold its value in all other states, including WAIT, REL and HALT.
REQ-028 PC wrap-around SHALL not be special-cased: an incr issued at pc=63 lets the PC wrap to 0, and fetching continues from address 0.
REQ-029 An ext_ready pulse shorter than 2 cycles MAY be missed; an ext_ready that is already high on entry to WAIT SHALL move the FSM to REL on the first cycle that ext_sync==1.

Reset
REQ-030 While reset is high, state SHALL be FETCH, instr SHALL be 0, both synchronizer flops SHALL be 0, and incr, instr_valid and halted SHALL be 0.
REQ-031 Reset SHALL act asynchronously from any state, including mid-WAIT, REL or HALT, with no pending incr surviving.
REQ-032 After reset deasserts, the first LATCH SHALL occur on the 2nd rising edge after reset release, fetching address 0.

Verification
REQ-033 Scenario, normal run: memory holds 3 instructions with op=4'h1, reset released -> incr pulses at cycles 3, 6, 9 counted from release, instr_valid is coincident with each pulse, and pc steps 0,1,2,3.
REQ-034 Scenario, wait handshake: instruction at address 2 has op=4'hE, and ext_ready rises 10 cycles after EXEC then falls 5 cycles later -> incr stays 0 in WAIT/REL, then a single incr pulse 2 cycles after ext_ready falls, and pc goes 2 to 3.
REQ-035 Scenario, halt: instruction at address 4 has op=4'hF -> halted=1 permanently, pc stays at 4, and toggling ext_ready has no effect.
REQ-036 Scenario, wrap-around: memory is filled with op=4'h1 and the design runs 64 instructions -> pc goes 63 to 0, and the instr at the next LATCH equals mem[0].
REQ-037 Scenario, mid-operation reset: reset is asserted asynchronously (not on a clock edge) while in REL with ext_ready high -> all outputs go to 0 immediately, and after release the fetch restarts at address 0 with no extra incr.
REQ-038 Scenario, short pulse: a 1-cycle ext_ready glitch occurs in WAIT -> either no transition or a clean WAIT to REL to FETCH sequence, and never more than one incr.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer for a small microcoded core.
// It walks FETCH -> LATCH -> EXEC for every instruction and steps the
// external PC with a one-cycle incr pulse. A WAIT opcode parks the sequencer
// until an external push-button handshake has been pressed and released.
// A HALT opcode stops fetching until the next reset.
module fetch_ctrl #(
    parameter int                IW      = 16,
    parameter int                OPW     = 4,
    parameter logic [OPW-1:0]    WAIT_OP = OPW'(4'hE),
    parameter logic [OPW-1:0]    HALT_OP = OPW'(4'hF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    pc,
    input  logic [IW-1:0] imem_data,
    input  logic          ext_ready,
    output logic          incr,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_LATCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WAIT  = 3'd3,
        S_REL   = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            sync1_reg;
    logic            sync2_reg;
    logic [IW-1:0]   instr_reg;
    logic            ext_sync;
    logic [OPW-1:0]  op;

    // pc only addresses the program memory; the sequencer never needs its value.
    logic unused_pc;
    assign unused_pc = ^pc;

    assign ext_sync = sync2_reg;
    assign op       = instr_reg[IW-1 -: OPW];
    assign instr    = instr_reg;

    // Two-flop synchronizer: ext_ready is a raw button/switch level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= ext_ready;
            sync2_reg <= sync1_reg;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Instruction register: memory data is valid during LATCH and held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_reg <= '0;
        end else if (state_reg == S_LATCH) begin
            instr_reg <= imem_data;
        end
    end

    // Next-state and output decode; outputs depend only on registered signals
    // so the PC sees a clean incr on the edge that leaves the state.
    always_comb begin
        state_next  = state_reg;
        incr        = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_reg)
            S_FETCH: state_next = S_LATCH;
            S_LATCH: state_next = S_EXEC;
            S_EXEC: begin
                instr_valid = 1'b1;
                if (op == HALT_OP) begin
                    state_next = S_HALT;
                end else if (op == WAIT_OP) begin
                    state_next = S_WAIT;
                end else begin
                    incr       = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_WAIT: begin
                if (ext_sync) begin
                    state_next = S_REL;
                end
            end
            S_REL: begin
                // Advance only once the button has been let go.
                if (!ext_sync) begin
                    incr       = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_next = S_FETCH;
        endcase
    end

endmodule
